// File: rtl/tls_pkg.sv
// rtl/tls_pkg.sv - light codes, phase encoding and board helpers for the junction scheduler
package tls_pkg;

   localparam logic [4:0] LIGHT_RED   = 5'b10000;
   localparam logic [4:0] LIGHT_GREEN = 5'b00111;
   localparam logic [4:0] LIGHT_AMBER = 5'b01000;

   localparam logic [1:0] BOARD_B = 2'd0;
   localparam logic [1:0] BOARD_L = 2'd1;
   localparam logic [1:0] BOARD_F = 2'd2;
   localparam logic [1:0] BOARD_R = 2'd3;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      AMBER   = 2'd2
   } phase_t;

   // Index of the lowest set bit; callers only use it on a non-zero vector.
   function automatic logic [1:0] lowest_index(input logic [3:0] v);
      logic [1:0] idx;
      casez (v)
         4'b???1: idx = BOARD_B;
         4'b??10: idx = BOARD_L;
         4'b?100: idx = BOARD_F;
         default: idx = BOARD_R;
      endcase
      return idx;
   endfunction

   // Full 20-bit board pattern: selected board shows the phase colour, the rest red.
   function automatic logic [19:0] board_lights(input phase_t ph, input logic [1:0] sel);
      logic [19:0] v;
      v = {4{LIGHT_RED}};
      for (int i = 0; i < 4; i++) begin
         if (2'(i) == sel) begin
            if (ph == GREEN) begin
               v[i*5 +: 5] = LIGHT_GREEN;
            end else if (ph == AMBER) begin
               v[i*5 +: 5] = LIGHT_AMBER;
            end
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/grant_select.sv
// rtl/grant_select.sv - picks the next green board from emergency, load and round-robin sources
module grant_select
   import tls_pkg::*;
(
   input  logic [3:0] emer_req,
   input  logic [3:0] load_req,
   input  logic [1:0] board_sel,
   output logic [1:0] grant,
   output logic       is_emer
);

   logic [3:0] load_others;
   logic [3:0] load_cand;

   // Emergency beats load beats round-robin; a loaded board yields to any other loaded board.
   always_comb begin
      grant       = board_sel + 2'd1;
      is_emer     = 1'b0;
      load_others = load_req & ~(4'b0001 << board_sel);
      load_cand   = (load_others != 4'd0) ? load_others : load_req;
      if (emer_req != 4'd0) begin
         grant   = lowest_index(emer_req);
         is_emer = 1'b1;
      end else if (load_req != 4'd0) begin
         grant = lowest_index(load_cand);
      end
   end

endmodule

// File: rtl/signal_phase_scheduler.sv
// rtl/signal_phase_scheduler.sv - green/amber/all-red sequencer for the four junction boards
module signal_phase_scheduler
   import tls_pkg::*;
#(
   parameter int GREEN_TICKS  = 16,
   parameter int AMBER_TICKS  = 4,
   parameter int ALLRED_TICKS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [3:0]  load_req,
   input  logic [3:0]  emer_req,
   output logic [19:0] lights,
   output logic [1:0]  board_sel,
   output logic [3:0]  countdown,
   output logic        emer_active,
   output logic        phase_start
);

   localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_TICKS - 1);
   localparam logic [3:0] AMBER_LOAD  = 4'(AMBER_TICKS - 1);
   localparam logic [3:0] ALLRED_LOAD = 4'(ALLRED_TICKS - 1);

   phase_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [1:0] sel_nxt;
   logic       emer_nxt;
   logic       start_nxt;
   logic [3:0] others_emer;
   logic [1:0] grant;
   logic       grant_is_emer;

   grant_select u_grant (
      .emer_req  (emer_req),
      .load_req  (load_req),
      .board_sel (board_sel),
      .grant     (grant),
      .is_emer   (grant_is_emer)
   );

   // Phase sequencing: everything moves only on tick; cnt==0 on a tick ends the phase.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sel_nxt     = board_sel;
      emer_nxt    = emer_active;
      start_nxt   = 1'b0;
      others_emer = emer_req & ~(4'b0001 << board_sel);
      if (tick) begin
         case (state)
            ALL_RED: begin
               if (cnt == 4'd0) begin
                  state_nxt = GREEN;
                  cnt_nxt   = GREEN_LOAD;
                  sel_nxt   = grant;
                  emer_nxt  = grant_is_emer;
                  start_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            GREEN: begin
               if (others_emer != 4'd0) begin
                  state_nxt = AMBER;
                  cnt_nxt   = AMBER_LOAD;
               end else if (cnt == 4'd0) begin
                  if (emer_req[board_sel]) begin
                     cnt_nxt  = GREEN_LOAD;
                     emer_nxt = 1'b1;
                  end else begin
                     state_nxt = AMBER;
                     cnt_nxt   = AMBER_LOAD;
                  end
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            AMBER: begin
               if (cnt == 4'd0) begin
                  state_nxt = ALL_RED;
                  cnt_nxt   = ALLRED_LOAD;
                  emer_nxt  = 1'b0;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            default: begin
               state_nxt = ALL_RED;
               cnt_nxt   = ALLRED_LOAD;
               emer_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State, counter and registered outputs; reset drops the junction to all-red at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ALL_RED;
         cnt         <= ALLRED_LOAD;
         board_sel   <= BOARD_R;
         emer_active <= 1'b0;
         phase_start <= 1'b0;
         lights      <= {4{LIGHT_RED}};
         countdown   <= 4'd0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         board_sel   <= sel_nxt;
         emer_active <= emer_nxt;
         phase_start <= start_nxt;
         lights      <= board_lights(state_nxt, sel_nxt);
         countdown   <= (state_nxt == ALL_RED) ? 4'd0 : cnt_nxt;
      end
   end

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// tb/tb_signal_phase_scheduler.sv - vector table, directed corner cases and random run against a phase model
module tb_signal_phase_scheduler;

   localparam int G = 16;
   localparam int A = 4;
   localparam int R = 2;
   localparam logic [19:0] ALL_RED_PAT = 20'h84210;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic [3:0]  load_req;
   logic [3:0]  emer_req;
   logic [19:0] lights;
   logic [1:0]  board_sel;
   logic [3:0]  countdown;
   logic        emer_active;
   logic        phase_start;

   int total = 0;
   int bad   = 0;

   // Reference model: 0 = all red, 1 = green, 2 = amber; m_left = ticks remaining after this one.
   int m_phase;
   int m_left;
   int m_board;
   bit m_emer;
   bit m_ps;
   int em_hold;

   typedef struct {
      bit          tk;
      logic [3:0]  ld;
      logic [3:0]  em;
      int          n;
      logic [1:0]  b;
      logic [3:0]  cd;
      logic [19:0] li;
      bit          ea;
      bit          ps;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   signal_phase_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .load_req    (load_req),
      .emer_req    (emer_req),
      .lights      (lights),
      .board_sel   (board_sel),
      .countdown   (countdown),
      .emer_active (emer_active),
      .phase_start (phase_start)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic int lowest_set(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [19:0] exp_lights(input int ph, input int b);
      logic [19:0] v;
      v = ALL_RED_PAT;
      if (ph == 1) v[b*5 +: 5] = 5'b00111;
      else if (ph == 2) v[b*5 +: 5] = 5'b01000;
      return v;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_left  = R - 1;
      m_board = 3;
      m_emer  = 1'b0;
      m_ps    = 1'b0;
   endtask

   task automatic model_step();
      int g;
      bit other;
      logic [3:0] rest;
      m_ps = 1'b0;
      if (tick !== 1'b1) return;
      if (m_phase == 0) begin
         if (m_left > 0) begin
            m_left--;
         end else begin
            if (emer_req != 4'd0) begin
               g = lowest_set(emer_req);
               m_emer = 1'b1;
            end else if (load_req != 4'd0) begin
               g = lowest_set(load_req);
               if (g == m_board && $countones(load_req) > 1) begin
                  rest = load_req;
                  rest[g] = 1'b0;
                  g = lowest_set(rest);
               end
               m_emer = 1'b0;
            end else begin
               g = (m_board + 1) % 4;
               m_emer = 1'b0;
            end
            m_board = g;
            m_phase = 1;
            m_left  = G - 1;
            m_ps    = 1'b1;
         end
      end else if (m_phase == 1) begin
         other = 1'b0;
         for (int i = 0; i < 4; i++) if (i != m_board && emer_req[i]) other = 1'b1;
         if (other) begin
            m_phase = 2;
            m_left  = A - 1;
         end else if (m_left == 0) begin
            if (emer_req[m_board]) begin
               m_left = G - 1;
               m_emer = 1'b1;
            end else begin
               m_phase = 2;
               m_left  = A - 1;
            end
         end else begin
            m_left--;
         end
      end else begin
         if (m_left == 0) begin
            m_phase = 0;
            m_left  = R - 1;
            m_emer  = 1'b0;
         end else begin
            m_left--;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".board"}, 32'(board_sel), 32'(m_board));
      chk({tag, ".countdown"}, 32'(countdown), (m_phase == 0) ? 32'd0 : 32'(m_left));
      chk({tag, ".lights"}, 32'(lights), 32'(exp_lights(m_phase, m_board)));
      chk({tag, ".emer_active"}, 32'(emer_active), 32'(m_emer));
      chk({tag, ".phase_start"}, 32'(phase_start), 32'(m_ps));
   endtask

   task automatic run(input int n, input bit cmp, input string tag);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
         if (cmp) check_model(tag);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".lights"}, 32'(lights), 32'(ALL_RED_PAT));
      chk({tag, ".countdown"}, 32'(countdown), 32'd0);
      chk({tag, ".board"}, 32'(board_sel), 32'd3);
      chk({tag, ".emer_active"}, 32'(emer_active), 32'd0);
      chk({tag, ".phase_start"}, 32'(phase_start), 32'd0);
   endtask

   initial begin
      reset    = 1'b0;
      tick     = 1'b0;
      load_req = 4'd0;
      emer_req = 4'd0;
      em_hold  = 0;

      vecs[0]  = '{1'b1, 4'h0, 4'h0, 1,  2'd3, 4'd0,  20'h84210, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'h0, 4'h0, 1,  2'd0, 4'd15, 20'h84207, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 4'h0, 4'h0, 3,  2'd0, 4'd15, 20'h84207, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 4'h0, 4'h0, 5,  2'd0, 4'd10, 20'h84207, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 4'h0, 4'h8, 1,  2'd0, 4'd3,  20'h84208, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 4'h0, 4'h8, 4,  2'd0, 4'd0,  20'h84210, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 4'h0, 4'h8, 2,  2'd3, 4'd15, 20'h3C210, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 4'h0, 4'h8, 16, 2'd3, 4'd15, 20'h3C210, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 4'h0, 4'h0, 16, 2'd3, 4'd3,  20'h44210, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 4'h0, 4'h0, 4,  2'd3, 4'd0,  20'h84210, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 4'h1, 4'h0, 2,  2'd0, 4'd15, 20'h84207, 1'b0, 1'b1};

      #12;
      check_reset_outputs("reset");
      reset = 1'b1;
      model_reset();

      // Vector table: hold each input set for n clocks, then compare.
      for (int i = 0; i < 11; i++) begin
         tick     = vecs[i].tk;
         load_req = vecs[i].ld;
         emer_req = vecs[i].em;
         run(vecs[i].n, 1'b0, "vec");
         chk($sformatf("vec%0d.board", i), 32'(board_sel), 32'(vecs[i].b));
         chk($sformatf("vec%0d.countdown", i), 32'(countdown), 32'(vecs[i].cd));
         chk($sformatf("vec%0d.lights", i), 32'(lights), 32'(vecs[i].li));
         chk($sformatf("vec%0d.emer_active", i), 32'(emer_active), 32'(vecs[i].ea));
         chk($sformatf("vec%0d.phase_start", i), 32'(phase_start), 32'(vecs[i].ps));
      end

      // Round-robin with no requests: 0,1,2,3,0 after a fresh reset.
      load_req = 4'd0;
      emer_req = 4'd0;
      tick     = 1'b1;
      reset    = 1'b0;
      #1;
      reset    = 1'b1;
      model_reset();
      for (int k = 0; k < 5; k++) begin
         run(R, 1'b1, "rr");
         chk($sformatf("rr%0d.grant", k), 32'(board_sel), 32'(k % 4));
         run(G + A, 1'b1, "rr");
      end

      // Load sequences: single load bit sticks, two load bits alternate.
      load_req = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         run(R + G + A, 1'b1, "load1");
         chk("load1.grant", 32'(board_sel), 32'd2);
      end
      load_req = 4'b0110;
      run(R + G + A, 1'b1, "load2");
      chk("load2.first", 32'(board_sel), 32'd1);
      run(R + G + A, 1'b1, "load2");
      chk("load2.second", 32'(board_sel), 32'd2);
      run(R + G + A, 1'b1, "load2");
      chk("load2.third", 32'(board_sel), 32'd1);
      load_req = 4'd0;

      // Two emergencies at the all-red exit: board 1 first, board 3 preempts on the next tick.
      reset = 1'b0;
      #1;
      reset = 1'b1;
      model_reset();
      run(1, 1'b1, "emer2");
      emer_req = 4'b1010;
      run(1, 1'b1, "emer2");
      chk("emer2.grant1", 32'(board_sel), 32'd1);
      chk("emer2.active1", 32'(emer_active), 32'd1);
      run(1, 1'b1, "emer2");
      chk("emer2.preempt_cd", 32'(countdown), 32'd3);
      chk("emer2.preempt_lights", 32'(lights), 32'h84110);
      emer_req = 4'b1000;
      run(A + R, 1'b1, "emer2");
      chk("emer2.grant3", 32'(board_sel), 32'd3);
      chk("emer2.active3", 32'(emer_active), 32'd1);

      // Reset pulled low mid-amber takes effect without waiting for a clock edge.
      emer_req = 4'd0;
      run(G + 1, 1'b1, "amber");
      chk("amber.entered", 32'(lights), 32'h44210);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      #1;
      reset = 1'b1;
      model_reset();
      run(R, 1'b1, "after_reset");
      chk("after_reset.grant", 32'(board_sel), 32'd0);
      chk("after_reset.cd", 32'(countdown), 32'd15);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         tick = ($urandom_range(0, 3) != 0);
         if (em_hold > 0) begin
            em_hold--;
         end else begin
            emer_req = 4'd0;
            if ($urandom_range(0, 39) == 0) begin
               emer_req = 4'($urandom_range(1, 15));
               em_hold  = int'($urandom_range(3, 40));
            end
         end
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 3))
               0:       load_req = 4'd0;
               1:       load_req = 4'b0100;
               2:       load_req = 4'b0110;
               default: load_req = 4'($urandom_range(0, 15));
            endcase
         end
         run(1, 1'b1, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
